// File: rtl/seg7_mux_driver.sv
// ---------------------------------------------------------------------------
// seg7_mux_driver
//
// Multiplexed seven-segment display driver for the hack computer's
// memory-mapped display output. Drives NUM_DIGITS digits by time-slicing,
// with PWM brightness, a dead time at the start of every digit slot to
// avoid ghosting, and per-digit blanking.
//
// Display data is double-buffered. A load strobe writes the pending buffer.
// The pending buffer is copied to the active buffer only at the end of a
// frame, so a frame never shows a mix of old and new data.
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading
// zeros. The suppression mask is computed when data is committed. Digit 0
// is never suppressed. When the macro is undefined, zeros are always shown.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   load           one-cycle strobe; captures digits/dp/blank/bright
//   digits         4*NUM_DIGITS hex nibbles, digit 0 in the LSBs (rightmost)
//   dp             decimal point per digit
//   blank          per-digit force-dark
//   bright         brightness, duty = bright / 2^BRIGHT_BITS
//   seg            segments {G,F,E,D,C,B,A}
//   seg_dp         decimal point segment
//   cc             digit selects, cc[0] drives CC1
//   frame_tick     one-cycle pulse in the cycle after the last slot ends
//   update_pending high while loaded data has not yet been committed
// ---------------------------------------------------------------------------
module seg7_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1024,
    parameter int BRIGHT_BITS    = 4,
    parameter int DEAD_CYCLES    = 8,
    parameter int CC_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [BRIGHT_BITS-1:0]  bright,
    output logic [6:0]              seg,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   cc,
    output logic                    frame_tick,
    output logic                    update_pending
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [NUM_DIGITS-1:0] CC_IDLE  = (CC_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic                  DP_IDLE  = (SEG_ACTIVE_LOW != 0);

    logic [PW-1:0] pre_cnt;
    logic [IW-1:0] idx;
    logic          slot_wrap;
    logic          frame_end;

    logic [4*NUM_DIGITS-1:0] pend_digits;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [BRIGHT_BITS-1:0]  pend_bright;

    logic [4*NUM_DIGITS-1:0] act_digits;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;
    logic [BRIGHT_BITS-1:0]  act_bright;

    logic [4*NUM_DIGITS-1:0] commit_digits;
    logic [NUM_DIGITS-1:0]   commit_dp;
    logic [NUM_DIGITS-1:0]   commit_blank;
    logic [BRIGHT_BITS-1:0]  commit_bright;

    logic [NUM_DIGITS-1:0]   blank_eff;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [BRIGHT_BITS-1:0]  phase;
    logic                    lit;
    logic [6:0]              seg_on;
    logic [NUM_DIGITS-1:0]   cc_on;

    assign slot_wrap = (pre_cnt == PW'(REFRESH_DIV - 1));
    assign frame_end = slot_wrap && (idx == IW'(NUM_DIGITS - 1));

    // Slot prescaler and digit index. The index advances when the
    // prescaler wraps and itself wraps after the last digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else begin
            pre_cnt <= slot_wrap ? '0 : pre_cnt + PW'(1);
            if (slot_wrap) begin
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
            end
        end
    end

    // The commit source is the pending buffer, unless a load arrives on
    // the frame_end cycle itself. In that case the fresh data bypasses
    // straight into the active buffer.
    always_comb begin
        commit_digits = pend_digits;
        commit_dp     = pend_dp;
        commit_blank  = pend_blank;
        commit_bright = pend_bright;
        if (load) begin
            commit_digits = digits;
            commit_dp     = dp;
            commit_blank  = blank;
            commit_bright = bright;
        end
    end

    // Pending buffer always holds the most recent load, so a later commit
    // never resurrects older data. update_pending tracks whether that load
    // has reached the active buffer yet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_digits    <= '0;
            pend_dp        <= '0;
            pend_blank     <= '0;
            pend_bright    <= '0;
            act_digits     <= '0;
            act_dp         <= '0;
            act_blank      <= '0;
            act_bright     <= '0;
            update_pending <= 1'b0;
        end else begin
            if (load) begin
                pend_digits <= digits;
                pend_dp     <= dp;
                pend_blank  <= blank;
                pend_bright <= bright;
            end
            if (frame_end) begin
                act_digits     <= commit_digits;
                act_dp         <= commit_dp;
                act_blank      <= commit_blank;
                act_bright     <= commit_bright;
                update_pending <= 1'b0;
            end else if (load) begin
                update_pending <= 1'b1;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] act_lzb;
    logic [NUM_DIGITS-1:0] commit_lzb;

    // A digit is a leading zero when it and every more-significant digit
    // are zero. Scanning from the top keeps a running "all zero so far".
    always_comb begin
        logic zero_above;
        commit_lzb = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (commit_digits[4*i +: 4] == 4'h0);
            commit_lzb[i] = zero_above;
        end
    end

    // The suppression mask is captured alongside the committed data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_lzb <= '0;
        end else if (frame_end) begin
            act_lzb <= commit_lzb;
        end
    end

    assign blank_eff = act_blank | act_lzb;
`else
    assign blank_eff = act_blank;
`endif

    // Select the active digit's data for the current slot.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nibble = act_digits[4*i +: 4];
                cur_dp     = act_dp[i];
                cur_blank  = blank_eff[i];
            end
        end
    end

    // The PWM phase is the top BRIGHT_BITS of the prescaler, so duty
    // resolution scales with the slot length.
    assign phase = pre_cnt[PW-1 -: BRIGHT_BITS];
    assign lit   = (pre_cnt >= PW'(DEAD_CYCLES)) && (phase < act_bright) && !cur_blank;

    // Hex decode, segments ordered {G,F,E,D,C,B,A}, active-high.
    always_comb begin
        seg_on = 7'h00;
        unique case (cur_nibble)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            4'hF: seg_on = 7'h71;
        endcase
    end

    assign cc_on = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

    // Output registers. Polarity is applied only here, so the internal
    // logic is always active-high and idle values come from the polarity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cc         <= CC_IDLE;
            seg        <= SEG_IDLE;
            seg_dp     <= DP_IDLE;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (lit) begin
                cc     <= cc_on ^ CC_IDLE;
                seg    <= seg_on ^ SEG_IDLE;
                seg_dp <= cur_dp ^ DP_IDLE;
            end else begin
                cc     <= CC_IDLE;
                seg    <= SEG_IDLE;
                seg_dp <= DP_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_mux_driver
//
// Self-checking bench for seg7_mux_driver with a 4-digit, 16-clock-slot
// configuration. The reference model describes the display in terms of
// absolute cycle numbers since reset release: frames are 64 clocks, each
// digit owns a 16-clock slot, and the active data is whatever was last
// loaded at or before the most recent frame end.
// ---------------------------------------------------------------------------
module tb_seg7_mux_driver;

    localparam int ND  = 4;
    localparam int RD  = 16;
    localparam int BB  = 2;
    localparam int DC  = 2;
    localparam int FRM = ND * RD;
    localparam int PHASE_DIV = RD / (1 << BB);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [1:0]  bright = '0;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  cc;
    logic        frame_tick;
    logic        update_pending;

    int totalChecks = 0;
    int badChecks   = 0;

    // Model state: pending/active display data and cycle number since
    // reset release.
    logic [15:0] pDig, aDig;
    logic [3:0]  pDp, aDp, pBl, aBl;
    logic [1:0]  pBr, aBr;
    logic        expUp;
    int          k;

    always #5 clk = ~clk;

    seg7_mux_driver #(
        .NUM_DIGITS(ND),
        .REFRESH_DIV(RD),
        .BRIGHT_BITS(BB),
        .DEAD_CYCLES(DC),
        .CC_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .digits(digits),
        .dp(dp),
        .blank(blank),
        .bright(bright),
        .seg(seg),
        .seg_dp(seg_dp),
        .cc(cc),
        .frame_tick(frame_tick),
        .update_pending(update_pending)
    );

    // Reference glyph table for {G,F,E,D,C,B,A}.
    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        logic [6:0] table_q [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                     7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return table_q[n];
    endfunction

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s k=%0d got=%0h want=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic modelReset();
        pDig = '0; aDig = '0;
        pDp = '0;  aDp = '0;
        pBl = '0;  aBl = '0;
        pBr = '0;  aBr = '0;
        expUp = 1'b0;
        k = 0;
    endtask

    // Called at a negedge: drives one cycle of input, predicts the outputs
    // registered by the next posedge, then checks them just after it.
    task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic [3:0] p,
                                 input logic [3:0] b, input logic [1:0] br);
        int pre, slot;
        logic lit, sup, tickExp, dpExp;
        logic [3:0] ccExp;
        logic [6:0] segExp;

        load = ld;
        if (ld) begin
            digits = d; dp = p; blank = b; bright = br;
        end

        pre  = k % RD;
        slot = (k / RD) % ND;
        sup  = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        sup = (slot != 0) && ((aDig >> (4 * slot)) == 16'h0);
`endif
        lit     = (pre >= DC) && ((pre / PHASE_DIV) < int'(aBr)) && !aBl[slot] && !sup;
        ccExp   = lit ? ~(4'b0001 << slot) : 4'hF;
        segExp  = lit ? hexSeg(aDig[4*slot +: 4]) : 7'h00;
        dpExp   = lit && aDp[slot];
        tickExp = ((k % FRM) == FRM - 1);

        if (ld) begin
            pDig = d; pDp = p; pBl = b; pBr = br;
        end
        if (tickExp) begin
            aDig = pDig; aDp = pDp; aBl = pBl; aBr = pBr;
            expUp = 1'b0;
        end else if (ld) begin
            expUp = 1'b1;
        end

        @(posedge clk);
        #1;
        checkOutput("cc", 32'(cc), 32'(ccExp));
        checkOutput("seg", 32'(seg), 32'(segExp));
        checkOutput("seg_dp", 32'(seg_dp), 32'(dpExp));
        checkOutput("frame_tick", 32'(frame_tick), 32'(tickExp));
        checkOutput("update_pending", 32'(update_pending), 32'(expUp));
        load = 1'b0;
        @(negedge clk);
        k++;
    endtask

    task automatic idleUntil(input int ph);
        while ((k % FRM) != ph) applyStimulus(1'b0, '0, '0, '0, '0);
    endtask

    task automatic idleFor(input int n);
        repeat (n) applyStimulus(1'b0, '0, '0, '0, '0);
    endtask

    task automatic checkDark(input string tag);
        checkOutput({tag, "_cc"}, 32'(cc), 32'hF);
        checkOutput({tag, "_seg"}, 32'(seg), 32'h0);
        checkOutput({tag, "_dp"}, 32'(seg_dp), 32'h0);
        checkOutput({tag, "_tick"}, 32'(frame_tick), 32'h0);
        checkOutput({tag, "_up"}, 32'(update_pending), 32'h0);
    endtask

    initial begin
        logic ld;
        int r;

        modelReset();
        #23;
        checkDark("reset");
        @(negedge clk);
        reset = 1'b1;
        modelReset();

        // Dark for three frames with frame_tick every 64 clocks.
        idleFor(3 * FRM);

        // Basic display, full brightness, decimal point on digit 2.
        idleUntil(10);
        applyStimulus(1'b1, 16'h1234, 4'b0100, 4'b0000, 2'd3);
        idleFor(2 * FRM);

        // Minimum and zero brightness.
        idleUntil(5);
        applyStimulus(1'b1, 16'h8888, 4'b0000, 4'b0000, 2'd1);
        idleFor(2 * FRM);
        applyStimulus(1'b1, 16'h8888, 4'b1111, 4'b0000, 2'd0);
        idleFor(2 * FRM);

        // Two loads in one frame: only the later must ever appear.
        idleUntil(20);
        applyStimulus(1'b1, 16'hAAAA, 4'b0000, 4'b0000, 2'd3);
        idleUntil(40);
        applyStimulus(1'b1, 16'h5555, 4'b0000, 4'b0000, 2'd3);
        idleFor(2 * FRM);

        // Load on the frame_end cycle goes straight to the display.
        idleUntil(FRM - 1);
        applyStimulus(1'b1, 16'h9C3E, 4'b1010, 4'b0010, 2'd2);
        idleFor(2 * FRM);

        // Leading zero patterns (suppressed only when the feature is built in).
        applyStimulus(1'b1, 16'h0050, 4'b0000, 4'b0000, 2'd3);
        idleFor(2 * FRM);
        applyStimulus(1'b1, 16'h0000, 4'b0000, 4'b0000, 2'd3);
        idleFor(2 * FRM);

        // Mid-frame reset discards pending data and blacks out at once.
        idleUntil(30);
        applyStimulus(1'b1, 16'h7777, 4'b1111, 4'b0000, 2'd3);
        reset = 1'b0;
        #1;
        checkDark("midreset");
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        idleFor(2 * FRM);

        // Randomized loads, biased toward the frame_end cycle.
        repeat (2500) begin
            r  = $urandom_range(0, 19);
            ld = (r == 0) || (((k % FRM) == FRM - 1) && (r < 6));
            applyStimulus(ld, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)),
                          2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
